systolic_job_ctrl: RTL and testbench



---
 rtl/systolic_job_ctrl_pkg.sv | 22 ++
 rtl/systolic_job_ctrl_serializer.sv | 42 ++++
 rtl/systolic_job_ctrl.sv | 160 ++++++++++++++++
 tb/tb_systolic_job_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_job_ctrl_pkg.sv
// systolic_job_ctrl shared types and constants.
// State encoding and word geometry for the job front end.
package systolic_job_ctrl_pkg;

  localparam int JOB_BYTES = 32;
  localparam int MAT_BYTES = 16;
  localparam int WORD_W    = 128;

  typedef enum logic [2:0] {
    S_FILL,
    S_LOAD,
    S_WAIT,
    S_LAG,
    S_DRAIN
  } state_t;

  // LSB position of byte i in a word; byte 0 is the top byte
  function automatic logic [6:0] byte_lsb(input logic [3:0] i);
    return 7'(WORD_W - 8) - {i, 3'b000};
  endfunction

endpackage

// File: rtl/systolic_job_ctrl_serializer.sv
// job_byte_serializer: holds one 128-bit result and
// streams it out top byte first over valid/ready.
module job_byte_serializer
  import systolic_job_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              done
);

  logic [WORD_W-1:0] word;
  logic [3:0]        idx;
  logic              fire;

  assign fire     = out_valid && out_ready;
  assign out_data = word[byte_lsb(idx) +: 8];
  assign out_last = out_valid && (idx == 4'(MAT_BYTES - 1));
  assign done     = fire && out_last;

  // capture on load, then step the byte index per handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      word      <= data;
      idx       <= '0;
      out_valid <= 1'b1;
    end else if (fire) begin
      idx <= idx + 4'd1;
      if (out_last) out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/systolic_job_ctrl.sv
// systolic_job_ctrl: packs a 32-byte job for the 4x4 array,
// issues one load, captures the result and streams it back.
module systolic_job_ctrl
  import systolic_job_ctrl_pkg::*;
#(
  parameter int TIMEOUT    = 31,
  parameter int RESULT_LAG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              arr_load,
  output logic [WORD_W-1:0] arr_feature,
  output logic [WORD_W-1:0] arr_wt,
  input  logic              arr_valid,
  input  logic [WORD_W-1:0] arr_result,
  input  logic              clr_err,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_spurious,
  output logic [15:0]       job_count
);

  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [1:0] LAG_LAST =
    2'((RESULT_LAG > 0) ? RESULT_LAG - 1 : 0);

  state_t     state, state_n;
  logic       ready_en;
  logic [4:0] idx;
  logic [6:0] lane;
  logic [7:0] wait_cnt;
  logic [1:0] lag_cnt;
  logic       accept;
  logic       capture;
  logic       timed_out;
  logic       done;
  logic       spurious;

  assign accept   = in_valid && in_ready;
  assign lane     = byte_lsb(idx[3:0]);
  assign spurious = arr_valid && (state != S_WAIT);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FILL;
    else       state <= state_n;
  end

  // next state and per-state control
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    arr_load  = 1'b0;
    capture   = 1'b0;
    timed_out = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_FILL: begin
        busy     = 1'b0;
        in_ready = ready_en;
        if (in_valid && ready_en &&
            idx == 5'(JOB_BYTES - 1))
          state_n = S_LOAD;
      end
      S_LOAD: begin
        arr_load = 1'b1;
        state_n  = S_WAIT;
      end
      S_WAIT: begin
        if (arr_valid) begin
          if (RESULT_LAG == 0) begin
            capture = 1'b1;
            state_n = S_DRAIN;
          end else begin
            state_n = S_LAG;
          end
        end else if (wait_cnt == TO_LAST) begin
          timed_out = 1'b1;
          state_n   = S_FILL;
        end
      end
      S_LAG: begin
        if (lag_cnt == LAG_LAST) begin
          capture = 1'b1;
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (done) state_n = S_FILL;
      end
      default: state_n = S_FILL;
    endcase
  end

  // byte packer: stream byte k lands in word byte k
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en    <= 1'b0;
      idx         <= '0;
      arr_feature <= '0;
      arr_wt      <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        if (idx[4]) arr_wt[lane +: 8]      <= in_data;
        else        arr_feature[lane +: 8] <= in_data;
        idx <= idx + 5'd1;
      end
      if (timed_out) idx <= '0;
    end
  end

  // wait-timeout and result-lag counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      lag_cnt  <= '0;
    end else begin
      if (state == S_LOAD)      wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 8'd1;
      if (state == S_WAIT)      lag_cnt <= '0;
      else if (state == S_LAG)  lag_cnt <= lag_cnt + 2'd1;
    end
  end

  // completed-job count and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      job_count    <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (done) job_count <= job_count + 16'd1;
      if (timed_out)    err_timeout <= 1'b1;
      else if (clr_err) err_timeout <= 1'b0;
      if (spurious)     err_spurious <= 1'b1;
      else if (clr_err) err_spurious <= 1'b0;
    end
  end

  job_byte_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (capture),
    .data      (arr_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
  );

endmodule

// File: tb/tb_systolic_job_ctrl.sv
// tb_systolic_job_ctrl: table-driven jobs, hand corner cases
// and randomized jobs checked against a job-level model.
module tb_systolic_job_ctrl;

  localparam int TO  = 31;
  localparam int LAG = 1;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         out_last;
  logic         arr_load;
  logic [127:0] arr_feature;
  logic [127:0] arr_wt;
  logic         arr_valid;
  logic [127:0] arr_result;
  logic         clr_err;
  logic         busy;
  logic         err_timeout;
  logic         err_spurious;
  logic [15:0]  job_count;

  int errors = 0;
  int checks = 0;
  int loads  = 0;
  int mcnt   = 0;
  bit mto    = 0;
  bit msp    = 0;

  typedef struct {
    logic [7:0]   base;
    int           dly;
    logic [127:0] res;
    int           stall;
    logic         exp_to;
    logic [15:0]  exp_cnt;
  } vec_t;

  systolic_job_ctrl #(.TIMEOUT(TO), .RESULT_LAG(LAG)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .arr_load     (arr_load),
    .arr_feature  (arr_feature),
    .arr_wt       (arr_wt),
    .arr_valid    (arr_valid),
    .arr_result   (arr_result),
    .clr_err      (clr_err),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious),
    .job_count    (job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (arr_load) loads++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // one whole job; dly=0 means the array never answers
  task automatic run_job(input logic [7:0] b [32], input int dly,
                         input logic [127:0] res, input int stall,
                         input bit spur, input bit gaps,
                         input int abort_at);
    logic [127:0] ef, ew, sh;
    logic [7:0]   got [$];
    bit           lst [$];
    logic [15:0]  lastv;
    logic [8:0]   hd;
    logic [5:0]   pat;
    bit           held, stab_bad, rdy_bad, ov;
    int           n, l0, p;
    pat = 6'b100101;
    l0 = loads;
    ef = '0;
    ew = '0;
    for (int k = 0; k < 16; k++) begin
      ef = {ef[119:0], b[k]};
      ew = {ew[119:0], b[k+16]};
    end
    for (int k = 0; k < 32; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      in_valid = 1'b1;
      in_data  = b[k];
      n = 0;
      while (!in_ready && n < 50) begin
        tick();
        n++;
      end
      if (!in_ready) begin
        check("in_ready_wait", in_ready, 1'b1);
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    check("load_pulse", arr_load, 1'b1);
    check("load_in_ready", in_ready, 1'b0);
    check("feature", arr_feature, ef);
    check("weight", arr_wt, ew);
    tick();
    check("load_one_cycle", arr_load, 1'b0);
    if (dly == 0) begin
      n = 1;
      ov = 0;
      while (busy && n < 400) begin
        if (out_valid) ov = 1;
        tick();
        n++;
      end
      check("timeout_cycles", 128'(n), 128'(TO + 1));
      check("timeout_no_out", ov | out_valid, 1'b0);
      check("timeout_in_ready", in_ready, 1'b1);
      check("timeout_loads", 128'(loads - l0), 128'(1));
      mto = 1;
      return;
    end
    repeat (dly - 1) tick();
    arr_valid  = 1'b1;
    arr_result = (LAG == 0) ? res : ~res;
    tick();
    arr_valid = 1'b0;
    for (int j = 1; j <= LAG; j++) begin
      arr_result = (j == LAG) ? res : ~res;
      tick();
    end
    arr_result = ~res;
    held = 0;
    stab_bad = 0;
    rdy_bad = 0;
    hd = '0;
    n = 0;
    p = 0;
    while (got.size() < 16 && n < 400) begin
      if (abort_at >= 0 && got.size() == abort_at && out_valid) begin
        sh = res >> (8 * (15 - abort_at));
        check("abort_byte", out_data, sh[7:0]);
        #2 reset = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_load", arr_load, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_count", job_count, 16'd0);
        check("abort_in_ready", in_ready, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        arr_valid = 1'b0;
        #3 reset = 1'b0;
        mcnt = 0;
        mto  = 0;
        msp  = 0;
        return;
      end
      arr_valid = 1'b0;
      if (spur && out_valid && $urandom_range(0, 7) == 0) begin
        arr_valid = 1'b1;
        msp = 1;
      end
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      case (stall)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[5 - (p % 6)];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      p++;
      if (out_valid && in_ready) rdy_bad = 1;
      if (out_valid && held && {out_last, out_data} !== hd)
        stab_bad = 1;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        lst.push_back(out_last);
        held = 0;
      end else if (out_valid) begin
        held = 1;
        hd = {out_last, out_data};
      end
      tick();
      n++;
    end
    arr_valid = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("drain_count", 128'(got.size()), 128'(16));
    if (got.size() < 16) return;
    lastv = '0;
    for (int i = 0; i < 16; i++) begin
      sh = res >> (8 * (15 - i));
      check($sformatf("out_byte%0d", i), got[i], sh[7:0]);
      lastv[i] = lst[i];
    end
    check("out_last_pos", lastv, 16'h8000);
    check("stall_stable", stab_bad, 1'b0);
    check("drain_in_ready", rdy_bad, 1'b0);
    check("end_out_valid", out_valid, 1'b0);
    check("end_busy", busy, 1'b0);
    check("end_in_ready", in_ready, 1'b1);
    check("job_loads", 128'(loads - l0), 128'(1));
    mcnt = (mcnt + 1) & 16'hFFFF;
  endtask

  initial begin
    vec_t         tbl [6];
    logic [7:0]   b [32];
    logic [127:0] r;
    int           d;

    tbl[0] = '{8'h01, 13,
               128'h00112233445566778899AABBCCDDEEFF,
               0, 1'b0, 16'd1};
    tbl[1] = '{8'h01, 5,
               128'hDEADBEEF0123456789ABCDEFCAFEF00D,
               1, 1'b0, 16'd2};
    tbl[2] = '{8'h80, 1,
               128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0,
               0, 1'b0, 16'd3};
    tbl[3] = '{8'h40, TO, 128'h1, 1, 1'b0, 16'd4};
    tbl[4] = '{8'h10, 0, 128'h0, 0, 1'b1, 16'd4};
    tbl[5] = '{8'hE0, 2,
               128'hA5A55A5A3C3CC3C3F00F0FF012344321,
               2, 1'b1, 16'd5};

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    arr_valid  = 1'b0;
    arr_result = '0;
    clr_err    = 1'b0;

    repeat (3) @(posedge clk);
    #3;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_arr_load", arr_load, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_feature", arr_feature, 128'h0);
    check("rst_out_data", {out_last, out_data}, 9'h0);
    check("rst_errs", {err_timeout, err_spurious}, 2'b00);
    reset = 1'b0;
    tick();
    check("first_in_ready", in_ready, 1'b1);
    check("first_job_count", job_count, 16'd0);
    check("first_busy", busy, 1'b0);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 32; k++) b[k] = 8'(tbl[t].base + 8'(k));
      run_job(b, tbl[t].dly, tbl[t].res, tbl[t].stall, 0, 0, -1);
      check($sformatf("tbl%0d_count", t), job_count, tbl[t].exp_cnt);
      check($sformatf("tbl%0d_err_to", t), err_timeout, tbl[t].exp_to);
      check($sformatf("tbl%0d_err_sp", t), err_spurious, 1'b0);
    end

    arr_valid = 1'b1;
    tick();
    arr_valid = 1'b0;
    check("spur_fill", err_spurious, 1'b1);
    arr_valid = 1'b1;
    clr_err   = 1'b1;
    tick();
    arr_valid = 1'b0;
    clr_err   = 1'b0;
    check("spur_set_wins", err_spurious, 1'b1);
    check("clr_timeout", err_timeout, 1'b0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_both", {err_timeout, err_spurious}, 2'b00);
    mto = 0;
    msp = 0;

    for (int j = 0; j < 20; j++) begin
      for (int k = 0; k < 32; k++) b[k] = 8'($urandom);
      r = {$urandom, $urandom, $urandom, $urandom};
      d = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO);
      run_job(b, d, r, 2, 1, 1, -1);
      check($sformatf("rnd%0d_count", j), job_count, 16'(mcnt));
      check($sformatf("rnd%0d_flags", j),
            {err_timeout, err_spurious}, {mto, msp});
      if ($urandom_range(0, 3) == 0) begin
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        mto = 0;
        msp = 0;
      end
    end

    for (int k = 0; k < 32; k++) b[k] = 8'(k + 1);
    run_job(b, 13, tbl[0].res, 0, 0, 0, 5);
    tick();
    run_job(b, 13, tbl[0].res, 0, 0, 0, -1);
    check("after_abort_count", job_count, 16'd1);
    check("after_abort_errs", {err_timeout, err_spurious}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
